// File: rtl/glm_op_sequencer_if.sv
// Host/unit bundle for glm_op_sequencer: program load, run control,
// op dispatch (op_start/op_regs) and completion (op_done), status.
// master: host/unit side driving program, run and op_done.
// slave : the sequencer driving op_start, op_regs, busy, run_done, error.
interface glm_op_sequencer_if #(
    parameter int NUM_UNITS       = 4,
    parameter int LOG2_PROG_DEPTH = 4
);
    logic                       prog_we;
    logic [LOG2_PROG_DEPTH-1:0] prog_waddr;
    logic [130:0]               prog_wdata;
    logic                       run_start;
    logic [LOG2_PROG_DEPTH:0]   run_length;
    logic [NUM_UNITS-1:0]       op_start;
    logic [3:0][31:0]           op_regs;
    logic [NUM_UNITS-1:0]       op_done;
    logic                       busy;
    logic                       run_done;
    logic                       error;

    modport master (
        output prog_we, prog_waddr, prog_wdata,
        output run_start, run_length, op_done,
        input  op_start, op_regs, busy, run_done, error
    );

    modport slave (
        input  prog_we, prog_waddr, prog_wdata,
        input  run_start, run_length, op_done,
        output op_start, op_regs, busy, run_done, error
    );
endinterface

// File: rtl/glm_op_sequencer.sv
// Program sequencer: runs a small instruction buffer, dispatching ops to
// NUM_UNITS units, with one-level LOOP, END and illegal-program detection.
// Ports: clk, reset (sync, active-high), sq (glm_op_sequencer_if.slave):
//   prog_we/prog_waddr/prog_wdata  program buffer write (IDLE only)
//   run_start/run_length           start a run of run_length entries
//   op_start/op_regs/op_done       unit dispatch and completion
//   busy/run_done/error            status
module glm_op_sequencer #(
    parameter int NUM_UNITS       = 4,
    parameter int LOG2_PROG_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    glm_op_sequencer_if.slave sq
);
    localparam int AW    = LOG2_PROG_DEPTH;
    localparam int DEPTH = 1 << AW;

    localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};
    localparam logic [3:0]  NU      = 4'(NUM_UNITS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_LOOP = 3'd4;
    localparam logic [2:0] OP_END  = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [AW-1:0]        pc_q, pc_d;
    logic [AW:0]          len_q, len_d;
    logic                 loop_q, loop_d;
    logic [15:0]          rem_q, rem_d;
    logic                 err_q, err_d;
    logic [2:0]           op_q, op_d;
    logic [AW-1:0]        tgt_q, tgt_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [NUM_UNITS-1:0] start_q, start_d;
    logic [NUM_UNITS-1:0] act_q, act_d;
    logic [3:0][31:0]     regs_q, regs_d;
    logic                 rdone_q, rdone_d;

    logic [130:0] mem_q [DEPTH];

    logic [130:0]         rd;
    logic [2:0]           rd_op;
    logic                 rd_unit;
    logic [NUM_UNITS-1:0] rd_hot;
    logic                 last_pc;
    logic                 x_loop;
    logic                 x_end;
    logic                 x_unit;
    logic [15:0]          eff_rem;
    logic                 done_hit;

    // Buffer is never reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (sq.prog_we && state_q == S_IDLE) begin
            mem_q[sq.prog_waddr] <= sq.prog_wdata;
        end
    end

    assign rd      = mem_q[pc_q];
    assign rd_op   = rd[130:128];
    assign rd_unit = (rd_op != OP_LOOP) && (rd_op != OP_END)
                   && ({1'b0, rd_op} < NU);
    assign rd_hot  = NUM_UNITS'(1) << rd_op;

    assign last_pc  = ({1'b0, pc_q} == (len_q - 1'b1));
    assign x_loop   = (op_q == OP_LOOP);
    assign x_end    = (op_q == OP_END);
    assign x_unit   = !x_loop && !x_end && ({1'b0, op_q} < NU);
    // First visit of a LOOP seeds the counter from the instruction.
    assign eff_rem  = loop_q ? rem_q : cnt_q;
    // act_q is only nonzero for the dispatched unit, so done pulses
    // from other units fall out of the mask.
    assign done_hit = |(sq.op_done & act_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        loop_d  = loop_q;
        rem_d   = rem_q;
        err_d   = err_q;
        op_d    = op_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        start_d = '0;
        act_d   = act_q;
        regs_d  = regs_q;
        rdone_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sq.run_start) begin
                    if (sq.run_length == '0 ||
                        sq.run_length > DEPTH_W) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d    = '0;
                        len_d   = sq.run_length;
                        loop_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                op_d  = rd_op;
                tgt_d = rd[AW-1:0];
                cnt_d = rd[31:16];
                act_d = '0;
                // Dispatch is registered here so op_start and op_regs
                // are both valid exactly in the EXEC cycle.
                if (rd_unit) begin
                    start_d = rd_hot;
                    act_d   = rd_hot;
                    regs_d  = rd[127:0];
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    x_loop: begin
                        if ({1'b0, tgt_q} >= len_q) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else if (eff_rem != 16'd0) begin
                            rem_d   = eff_rem - 16'd1;
                            loop_d  = 1'b1;
                            pc_d    = tgt_q;
                            state_d = S_FETCH;
                        end else begin
                            loop_d = 1'b0;
                            if (last_pc) begin
                                state_d = S_DONE;
                            end else begin
                                pc_d    = pc_q + 1'b1;
                                state_d = S_FETCH;
                            end
                        end
                    end
                    x_end: begin
                        state_d = S_DONE;
                    end
                    x_unit: begin
                        state_d = S_WAIT;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_WAIT: begin
                if (done_hit) begin
                    act_d = '0;
                    if (last_pc) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                rdone_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            op_q    <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            start_q <= '0;
            act_q   <= '0;
            regs_q  <= '0;
            rdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            act_q   <= act_d;
            regs_q  <= regs_d;
            rdone_q <= rdone_d;
        end
    end

    assign sq.op_start = start_q;
    assign sq.op_regs  = regs_q;
    assign sq.busy     = (state_q != S_IDLE);
    assign sq.run_done = rdone_q;
    assign sq.error    = err_q;
endmodule

// File: tb/tb_glm_op_sequencer.sv
// Self-checking bench for glm_op_sequencer: directed scenarios plus
// random programs checked against an instruction-level program model.
module tb_glm_op_sequencer;
    localparam int NU    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    glm_op_sequencer_if #(.NUM_UNITS(NU), .LOG2_PROG_DEPTH(AW)) sq ();

    glm_op_sequencer #(.NUM_UNITS(NU), .LOG2_PROG_DEPTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .sq    (sq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [130:0]   prog [DEPTH];
    logic [2:0]     exp_u [$];
    logic [127:0]   exp_r [$];
    bit             exp_err;
    logic [NU-1:0]  obs_s [$];
    logic [127:0]   obs_r [$];
    logic [127:0]   keep;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [130:0] mk(input logic [2:0] op,
        input logic [31:0] r0, input logic [31:0] r1,
        input logic [31:0] r2, input logic [31:0] r3);
        return {op, r3, r2, r1, r0};
    endfunction

    task automatic wr(input int a, input logic [130:0] d);
        sq.prog_we    = 1'b1;
        sq.prog_waddr = 4'(a);
        sq.prog_wdata = d;
        prog[a]       = d;
        @(negedge clk);
        sq.prog_we    = 1'b0;
    endtask

    // Instruction-level interpretation of the program rules.
    task automatic model(input int len);
        int pc;
        bit la;
        int rem;
        int tgt;
        logic [2:0] op;
        logic [31:0] r0;
        exp_u.delete();
        exp_r.delete();
        exp_err = 1'b0;
        pc = 0;
        la = 1'b0;
        rem = 0;
        for (int g = 0; g < 4096; g++) begin
            op = prog[pc][130:128];
            r0 = prog[pc][31:0];
            if (op < 3'(NU)) begin
                exp_u.push_back(op);
                exp_r.push_back(prog[pc][127:0]);
            end else if (op == 3'd4) begin
                tgt = int'(r0[3:0]);
                if (tgt >= len) begin
                    exp_err = 1'b1;
                    return;
                end
                if (!la) begin
                    rem = int'(r0[31:16]);
                    la = 1'b1;
                end
                if (rem > 0) begin
                    rem--;
                    pc = tgt;
                    continue;
                end
                la = 1'b0;
            end else if (op == 3'd5) begin
                return;
            end else begin
                exp_err = 1'b1;
                return;
            end
            if (pc == len - 1) return;
            pc++;
        end
    endtask

    // Starts a run from a negedge in IDLE and plays unit responders with
    // random latency until run_done; ends on the negedge after run_done.
    task automatic go(input int len, input int budget);
        logic [NU-1:0] pend;
        int lat;
        bit seen;
        obs_s.delete();
        obs_r.delete();
        sq.run_length = 5'(len);
        sq.run_start  = 1'b1;
        @(negedge clk);
        sq.run_start  = 1'b0;
        check("go_err_clr", sq.error, 0);
        check("go_busy", sq.busy, 1);
        pend = '0;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            sq.op_done = '0;
            if (pend != '0) begin
                if (lat == 0) begin
                    sq.op_done = pend;
                    pend = '0;
                end else begin
                    lat--;
                end
            end
            if (sq.op_start != '0) begin
                obs_s.push_back(sq.op_start);
                obs_r.push_back(sq.op_regs);
                pend = sq.op_start;
                lat  = $urandom_range(0, 3);
            end
            if (sq.run_done) seen = 1'b1;
            else @(negedge clk);
        end
        sq.op_done = '0;
        check("go_run_done", seen, 1);
        @(negedge clk);
        check("go_pulse", sq.run_done, 0);
        check("go_idle", sq.busy, 0);
    endtask

    task automatic compare(input string tag);
        logic [NU-1:0] e;
        check({tag, "_n"}, obs_s.size(), exp_u.size());
        for (int i = 0; i < exp_u.size() && i < obs_s.size(); i++) begin
            e = NU'(1) << exp_u[i];
            check({tag, "_start"}, obs_s[i], e);
            check({tag, "_regs"}, obs_r[i], exp_r[i]);
        end
        check({tag, "_err"}, sq.error, exp_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int lp;
        int r;
        logic [2:0] op;
        logic [3:0] tg;
        logic [15:0] cn;
        reset         = 1'b1;
        sq.prog_we    = 1'b0;
        sq.prog_waddr = '0;
        sq.prog_wdata = '0;
        sq.run_start  = 1'b0;
        sq.run_length = '0;
        sq.op_done    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", sq.busy, 0);
        check("rst_start", sq.op_start, 0);
        check("rst_regs", sq.op_regs, 0);
        check("rst_run_done", sq.run_done, 0);
        check("rst_error", sq.error, 0);

        // Single op, fixed timing, early done in EXEC is ignored.
        wr(0, mk(3'd0, 32'h00030004, 32'h11, 32'h22, 32'h33));
        sq.run_length = 5'd1;
        sq.run_start  = 1'b1;
        @(negedge clk);
        sq.run_start = 1'b0;
        check("v1_fetch", sq.op_start, 0);
        @(negedge clk);
        check("v1_start", sq.op_start, 4'b0001);
        check("v1_reg0", sq.op_regs[0], 32'h00030004);
        sq.op_done = 4'b0001;
        @(negedge clk);
        sq.op_done = '0;
        check("v1_start_once", sq.op_start, 0);
        repeat (3) @(negedge clk);
        check("v1_still_busy", sq.busy, 1);
        check("v1_regs_hold", sq.op_regs[0], 32'h00030004);
        sq.op_done = 4'b0001;
        @(negedge clk);
        sq.op_done = '0;
        check("v1_rd_early", sq.run_done, 0);
        @(negedge clk);
        check("v1_rd", sq.run_done, 1);
        @(negedge clk);
        check("v1_rd_pulse", sq.run_done, 0);
        check("v1_idle", sq.busy, 0);

        // Illegal opcode, then a valid run clears error.
        wr(0, mk(3'd7, 32'h1, 32'h2, 32'h3, 32'h4));
        model(1);
        go(1, 200);
        compare("v4");
        wr(0, mk(3'd3, 32'hA, 32'hB, 32'hC, 32'hD));
        model(1);
        go(1, 200);
        compare("v4b");

        // Out-of-range lengths flag error and stay idle.
        sq.run_length = 5'd0;
        sq.run_start  = 1'b1;
        @(negedge clk);
        sq.run_start = 1'b0;
        check("len0_err", sq.error, 1);
        check("len0_busy", sq.busy, 0);
        sq.run_length = 5'd17;
        sq.run_start  = 1'b1;
        @(negedge clk);
        sq.run_start = 1'b0;
        check("len17_err", sq.error, 1);
        check("len17_busy", sq.busy, 0);

        // Loop: 1,2,1,2,1,2.
        wr(0, mk(3'd1, 32'h100, 32'h101, 32'h102, 32'h103));
        wr(1, mk(3'd2, 32'h200, 32'h201, 32'h202, 32'h203));
        wr(2, mk(3'd4, {16'd2, 16'd0}, 32'h0, 32'h0, 32'h0));
        model(3);
        go(3, 500);
        compare("v2");
        check("v2_count", obs_s.size(), 6);
        for (int i = 0; i < 6 && i < obs_s.size(); i++) begin
            keep = (i % 2 == 0) ? 128'h2 : 128'h4;
            check("v2_seq", obs_s[i], keep);
        end

        // END stops before op3.
        wr(0, mk(3'd0, 32'h5, 32'h6, 32'h7, 32'h8));
        wr(1, mk(3'd5, 32'h0, 32'h0, 32'h0, 32'h0));
        wr(2, mk(3'd3, 32'h9, 32'h9, 32'h9, 32'h9));
        model(3);
        go(3, 300);
        compare("v3");
        check("v3_count", obs_s.size(), 1);

        // Foreign done ignored; run_start/prog_we while busy dropped.
        wr(0, mk(3'd2, 32'hC0DE0000, 32'h1, 32'h2, 32'h3));
        sq.run_length = 5'd1;
        sq.run_start  = 1'b1;
        @(negedge clk);
        sq.run_start = 1'b0;
        @(negedge clk);
        check("v5_start", sq.op_start, 4'b0100);
        @(negedge clk);
        sq.op_done    = 4'b0010;
        sq.run_start  = 1'b1;
        sq.prog_we    = 1'b1;
        sq.prog_waddr = 4'd0;
        sq.prog_wdata = mk(3'd1, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD);
        @(negedge clk);
        sq.op_done   = '0;
        sq.run_start = 1'b0;
        sq.prog_we   = 1'b0;
        check("v5_wait1", sq.busy, 1);
        @(negedge clk);
        check("v5_wait2", sq.busy, 1);
        check("v5_no_rd", sq.run_done, 0);
        sq.op_done = 4'b0100;
        @(negedge clk);
        sq.op_done = '0;
        @(negedge clk);
        check("v5_rd", sq.run_done, 1);
        @(negedge clk);
        model(1);
        go(1, 200);
        compare("v5_buf");

        // Reset while waiting aborts the run.
        wr(0, mk(3'd0, 32'h77, 32'h0, 32'h0, 32'h0));
        sq.run_length = 5'd1;
        sq.run_start  = 1'b1;
        @(negedge clk);
        sq.run_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("v6_busy", sq.busy, 0);
        check("v6_start", sq.op_start, 0);
        sq.op_done = 4'b0001;
        @(negedge clk);
        sq.op_done = '0;
        r = 0;
        repeat (4) begin
            @(negedge clk);
            r += int'(sq.run_done);
        end
        check("v6_no_rd", r, 0);

        // Random programs, at most one LOOP each.
        for (int t = 0; t < 12; t++) begin
            len = (t == 0) ? DEPTH : $urandom_range(1, DEPTH);
            lp  = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, len - 1);
            for (int a = 0; a < len; a++) begin
                r = $urandom_range(0, 19);
                if (a == lp) begin
                    op = 3'd4;
                    tg = 4'($urandom_range(0, len));
                    cn = 16'($urandom_range(0, 3));
                    wr(a, mk(op, {cn, 12'h0, tg}, $urandom(), $urandom(),
                             $urandom()));
                end else begin
                    if (r == 0) op = 3'd5;
                    else if (r == 1) op = 3'($urandom_range(6, 7));
                    else op = 3'($urandom_range(0, NU - 1));
                    wr(a, mk(op, $urandom(), $urandom(), $urandom(),
                             $urandom()));
                end
            end
            model(len);
            go(len, 3000);
            compare("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/glm_op_sequencer.md
GLM_OP_SEQUENCER -- requirements
Module: glm_op_sequencer

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of op units sequenced (opcodes 0..NUM_UNITS-1).
REQ-002 SHALL have parameter LOG2_PROG_DEPTH, default 4, program buffer depth 2^LOG2_PROG_DEPTH entries.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port prog_we  in  1  program buffer write strobe.
REQ-006 SHALL have port prog_waddr  in  LOG2_PROG_DEPTH  program write address.
REQ-007 SHALL have port prog_wdata  in  131  {opcode[130:128], regs[3..0] 32b each, regs[0] at [31:0]}.
REQ-008 SHALL have port run_start  in  1  start program at pc 0.
REQ-009 SHALL have port run_length  in  LOG2_PROG_DEPTH+1  instruction count, 1..2^LOG2_PROG_DEPTH.
REQ-010 SHALL have port op_start  out  NUM_UNITS  one-hot single-cycle start per unit.
REQ-011 SHALL have port op_regs  out  4x32  register operands to units, shared by all units.
REQ-012 SHALL have port op_done  in  NUM_UNITS  per-unit single-cycle completion pulse.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port run_done  out  1  single-cycle pulse at program completion.
REQ-015 SHALL have port error  out  1  sticky illegal-program flag, cleared by reset or accepted run_start.

Function
REQ-016 SHALL store entries from prog_we/prog_waddr/prog_wdata only in IDLE; writes outside IDLE are dropped.
REQ-017 SHALL implement states IDLE, FETCH, EXEC, WAIT, DONE.
REQ-018 IDLE: run_start with run_length in 1..depth -> pc=0, loop_active=0, error=0, FETCH; run_length 0 or >depth -> error=1, remain IDLE; run_start outside IDLE ignored.
REQ-019 FETCH: registered buffer read at pc, 1 cycle, -> EXEC.
REQ-020 EXEC, opcode k < NUM_UNITS: op_start[k]=1 for exactly this cycle, op_regs=fetched regs, -> WAIT.
REQ-021 op_regs SHALL hold stable from EXEC cycle until the matching op_done; otherwise hold last value.
REQ-022 WAIT: op_done[k] of active unit -> advance; op_done from other units ignored; no timeout.
REQ-023 op_done asserted in the same cycle as op_start SHALL not count; only from the cycle after EXEC.
REQ-024 Opcode 4 (LOOP): target=regs[0][LOG2_PROG_DEPTH-1:0], count=regs[0][31:16]; if !loop_active: remain=count, loop_active=1; if remain>0: remain-1, pc=target, FETCH; else loop_active=0, advance. Count 0 -> no jump. Executes in 1 EXEC cycle, no op_start.
REQ-025 Opcode 5 (END): -> DONE regardless of pc.
REQ-026 Opcodes 6,7, or opcode k>=NUM_UNITS, or LOOP target>=run_length: error=1, -> DONE, no op_start.
REQ-027 Advance: pc==run_length-1 -> DONE, else pc+1, FETCH.
REQ-028 DONE: run_done=1 one cycle, -> IDLE.
REQ-029 Single loop level: LOOP body SHALL not contain another LOOP; violating program reuses one counter (undefined iteration count, no hang beyond count bound).
REQ-030 Total cycles per dispatched instruction SHALL be 2 + unit latency (FETCH, EXEC, WAIT to done).

Reset
REQ-031 On reset: state IDLE, op_start=0, op_regs=0, busy=0, run_done=0, error=0, pc=0, loop_active=0, remain=0; program buffer contents not cleared.
REQ-032 Reset mid-operation SHALL abort immediately; later op_done pulses ignored; no run_done issued.

Verification
V-1 Program [op0 regs0=0x00030004], run_length=1; op_done[0] 5 cycles after op_start -> op_start[0] at cycle 2 after run_start, op_regs[0]=0x00030004, run_done 2 cycles after op_done.
V-2 Program [op1, op2, LOOP target0 count2], length 3 -> op_start sequence 1,2,1,2,1,2 then run_done; exactly 6 op_starts.
V-3 Program [op0, END, op3], length 3 -> only op_start[0], run_done, op3 never started.
V-4 Opcode 7 at pc0 -> error=1, run_done pulse, no op_start; next valid run_start clears error.
V-5 During WAIT for unit 2: op_done[1] pulse -> ignored, stays WAIT; op_done[2] -> proceeds; run_start and prog_we during busy -> ignored, buffer unchanged.
V-6 Reset asserted in WAIT -> next cycle busy=0, op_start=0; subsequent op_done[0] -> no run_done.
